// File: rtl/adder_tree_acc_ctrl_if.sv
// Handshake bundle between the reduction controller, the stream front-end,
// the external adder tree and the result consumer (ADDER_TREE_ACC_CTRL_PERF_EN adds perf counters).
interface adder_tree_acc_ctrl_if #(
    parameter int SUM_W     = 16,
    parameter int MAX_BEATS = 256
);
    localparam int BEAT_CNT_W = $clog2(MAX_BEATS + 1);
    localparam int ACC_W      = SUM_W + $clog2(MAX_BEATS);

    logic                  cfg_valid_i;
    logic                  cfg_ready_o;
    logic [BEAT_CNT_W-1:0] cfg_beats_i;
    logic                  cfg_signed_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic                  tree_launch_o;
    logic                  tree_sign_unsign_no;
    logic [SUM_W-1:0]      tree_sum_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [ACC_W-1:0]      out_result_o;
    logic                  busy_o;
`ifdef ADDER_TREE_ACC_CTRL_PERF_EN
    logic [31:0]           perf_busy_cycles_o;
    logic [31:0]           perf_stall_cycles_o;
`endif

    // Controller side.
    modport slave (
        input  cfg_valid_i, cfg_beats_i, cfg_signed_i, in_valid_i, tree_sum_i, out_ready_i,
        output cfg_ready_o, in_ready_o, tree_launch_o, tree_sign_unsign_no,
               out_valid_o, out_result_o, busy_o
`ifdef ADDER_TREE_ACC_CTRL_PERF_EN
        , output perf_busy_cycles_o, perf_stall_cycles_o
`endif
    );

    // Environment side: front-end, tree and consumer.
    modport master (
        output cfg_valid_i, cfg_beats_i, cfg_signed_i, in_valid_i, tree_sum_i, out_ready_i,
        input  cfg_ready_o, in_ready_o, tree_launch_o, tree_sign_unsign_no,
               out_valid_o, out_result_o, busy_o
`ifdef ADDER_TREE_ACC_CTRL_PERF_EN
        , input perf_busy_cycles_o, perf_stall_cycles_o
`endif
    );
endinterface

// File: rtl/adder_tree_acc_ctrl.sv
// Multi-beat reduction sequencer around a fixed-latency, non-stallable adder tree.
// Optional ADDER_TREE_ACC_CTRL_PERF_EN adds saturating busy/stall cycle counters.
module adder_tree_acc_ctrl #(
    parameter int SUM_W     = 16,
    parameter int TREE_LAT  = 2,
    parameter int MAX_BEATS = 256
) (
    input logic                  clk_i,
    input logic                  rst_i,
    adder_tree_acc_ctrl_if.slave bus
);
    localparam int BEAT_CNT_W = $clog2(MAX_BEATS + 1);
    localparam int ACC_W      = SUM_W + $clog2(MAX_BEATS);
    localparam logic [BEAT_CNT_W-1:0] ONE = BEAT_CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                state_q, state_d;
    logic [BEAT_CNT_W-1:0] beats_q, launched_q, retired_q;
    logic                  signed_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      sum_ext;
    logic                  cfg_rdy, in_rdy, out_vld;
    logic                  launch, retire_raw, retire, last_launch, last_retire;

    assign launch      = bus.in_valid_i & in_rdy;
    assign retire      = retire_raw & ((state_q == RUN) | (state_q == DRAIN));
    assign last_launch = launch & ((launched_q + ONE) == beats_q);
    assign last_retire = retire & ((retired_q + ONE) == beats_q);
    assign sum_ext     = signed_q ? {{(ACC_W-SUM_W){bus.tree_sum_i[SUM_W-1]}}, bus.tree_sum_i}
                                  : {{(ACC_W-SUM_W){1'b0}}, bus.tree_sum_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cfg_rdy = 1'b0;
        in_rdy  = 1'b0;
        out_vld = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_rdy = 1'b1;
                if (bus.cfg_valid_i)
                    state_d = (bus.cfg_beats_i == '0) ? DONE : RUN;
            end
            RUN: begin
                in_rdy = (launched_q < beats_q);
                // A combinational tree retires the last beat in its launch cycle.
                if (last_launch)
                    state_d = (TREE_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (last_retire) state_d = DONE;
            end
            DONE: begin
                out_vld = 1'b1;
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beats_q    <= '0;
            launched_q <= '0;
            retired_q  <= '0;
            signed_q   <= 1'b0;
            acc_q      <= '0;
        end else if (cfg_rdy && bus.cfg_valid_i) begin
            beats_q    <= bus.cfg_beats_i;
            signed_q   <= bus.cfg_signed_i;
            launched_q <= '0;
            retired_q  <= '0;
            acc_q      <= '0;
        end else begin
            if (launch) launched_q <= launched_q + ONE;
            if (retire) begin
                retired_q <= retired_q + ONE;
                acc_q     <= acc_q + sum_ext;
            end
        end
    end

    // Launch marker travels alongside the beat so its sum is picked up exactly TREE_LAT later.
    generate
        if (TREE_LAT == 0) begin : g_comb
            assign retire_raw = launch;
        end else if (TREE_LAT == 1) begin : g_pipe1
            logic vld_pipe;
            always_ff @(posedge clk_i) begin
                if (rst_i) vld_pipe <= 1'b0;
                else       vld_pipe <= launch;
            end
            assign retire_raw = vld_pipe;
        end else begin : g_pipe
            logic [TREE_LAT-1:0] vld_pipe;
            always_ff @(posedge clk_i) begin
                if (rst_i) vld_pipe <= '0;
                else       vld_pipe <= {vld_pipe[TREE_LAT-2:0], launch};
            end
            assign retire_raw = vld_pipe[TREE_LAT-1];
        end
    endgenerate

    assign bus.cfg_ready_o         = cfg_rdy;
    assign bus.in_ready_o          = in_rdy;
    assign bus.tree_launch_o       = launch;
    assign bus.tree_sign_unsign_no = signed_q;
    assign bus.out_valid_o         = out_vld;
    assign bus.out_result_o        = acc_q;
    assign bus.busy_o              = (state_q != IDLE);

`ifdef ADDER_TREE_ACC_CTRL_PERF_EN
    logic [31:0] busy_cyc_q, stall_cyc_q;
    logic        stall;

    assign stall = ((state_q == RUN) & in_rdy & ~bus.in_valid_i) |
                   ((state_q == DONE) & ~bus.out_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_cyc_q  <= '0;
            stall_cyc_q <= '0;
        end else begin
            if ((state_q != IDLE) && (busy_cyc_q != '1)) busy_cyc_q  <= busy_cyc_q + 32'd1;
            if (stall && (stall_cyc_q != '1))            stall_cyc_q <= stall_cyc_q + 32'd1;
        end
    end

    assign bus.perf_busy_cycles_o  = busy_cyc_q;
    assign bus.perf_stall_cycles_o = stall_cyc_q;
`else
    // Default build carries no performance counters.
`endif

`ifndef SYNTHESIS
    a_cfg_beats: assert property (@(posedge clk_i) disable iff (rst_i)
        (cfg_rdy && bus.cfg_valid_i) |-> (bus.cfg_beats_i <= BEAT_CNT_W'(MAX_BEATS)));
    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_vld && !bus.out_ready_i) |=> $stable(acc_q));
`endif
endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Randomised scoreboard bench: a behavioural tree delays beat sums, a reference
// model computes each job's result, and a monitor pops/compares on output handshakes.
module tb_adder_tree_acc_ctrl;
    localparam int SUM_W      = 16;
    localparam int TREE_LAT   = 2;
    localparam int MAX_BEATS  = 256;
    localparam int BEAT_CNT_W = $clog2(MAX_BEATS + 1);
    localparam int ACC_W      = SUM_W + $clog2(MAX_BEATS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_tree_acc_ctrl_if #(.SUM_W(SUM_W), .MAX_BEATS(MAX_BEATS)) bus ();

    adder_tree_acc_ctrl #(.SUM_W(SUM_W), .TREE_LAT(TREE_LAT), .MAX_BEATS(MAX_BEATS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               launches = 0;
    logic [ACC_W-1:0] exp_q[$];
    logic [SUM_W-1:0] sums [MAX_BEATS];
    logic [SUM_W-1:0] beat_sum = '0;
    logic [SUM_W-1:0] tdly [TREE_LAT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum of the job's beat sums, wrapped to ACC_W.
    function automatic logic [ACC_W-1:0] model(input int n, input bit s);
        longint tot = 0;
        for (int i = 0; i < n; i++)
            tot += s ? longint'($signed(sums[i])) : longint'(sums[i]);
        return ACC_W'(tot);
    endfunction

    // External tree: sum of a launched beat appears TREE_LAT cycles later, garbage otherwise.
    always @(posedge clk) begin
        tdly[0] <= bus.tree_launch_o ? beat_sum : SUM_W'($urandom);
        for (int i = 1; i < TREE_LAT; i++) tdly[i] <= tdly[i-1];
        cyc <= cyc + 1;
    end
    assign bus.tree_sum_i = tdly[TREE_LAT-1];

    always @(negedge clk) begin
        if (!rst && bus.tree_launch_o) launches++;
        if (!rst && bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h with no job outstanding", bus.out_result_o);
            end else begin
                chk("result", 64'(bus.out_result_o), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cfg_ready"}, 64'(bus.cfg_ready_o), 64'(1));
        chk({tag, "_in_ready"},  64'(bus.in_ready_o), 64'(0));
        chk({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'(0));
        chk({tag, "_busy"},      64'(bus.busy_o), 64'(0));
        chk({tag, "_result"},    64'(bus.out_result_o), 64'(0));
        chk({tag, "_sign"},      64'(bus.tree_sign_unsign_no), 64'(0));
        chk({tag, "_launch"},    64'(bus.tree_launch_o), 64'(0));
    endtask

    task automatic send_cfg(input int n, input bit s, input bit push, output int t0);
        int w = 0;
        while (!bus.cfg_ready_o && w < 200) begin tick(); w++; end
        chk("cfg_ready_wait", 64'(bus.cfg_ready_o), 64'(1));
        if (push) exp_q.push_back(model(n, s));
        bus.cfg_valid_i  = 1'b1;
        bus.cfg_beats_i  = BEAT_CNT_W'(n);
        bus.cfg_signed_i = s;
        tick();
        bus.cfg_valid_i  = 1'b0;
        t0 = cyc;
    endtask

    task automatic feed(input int n, input bit bubbles);
        int  i = 0;
        int  w = 0;
        bit  take;
        while (i < n && w < 4 * n + 50) begin
            bus.in_valid_i = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            beat_sum = sums[i];
            take = bus.in_valid_i && bus.in_ready_o;
            tick();
            w++;
            if (take) i++;
        end
        bus.in_valid_i = 1'b0;
        chk("beats_fed", 64'(i), 64'(n));
    endtask

    task automatic get_result(input int hold, input bit s, output int tv);
        int               w = 0;
        logic [ACC_W-1:0] r0;
        while (!bus.out_valid_o && w < 1000) begin tick(); w++; end
        tv = cyc;
        chk("out_valid_wait", 64'(bus.out_valid_o), 64'(1));
        chk("sign_held", 64'(bus.tree_sign_unsign_no), 64'(s));
        r0 = bus.out_result_o;
        repeat (hold) begin
            tick();
            chk("result_stable", 64'(bus.out_result_o), 64'(r0));
            chk("cfg_ready_in_done", 64'(bus.cfg_ready_o), 64'(0));
        end
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        chk("idle_after_out", 64'(bus.cfg_ready_o), 64'(1));
    endtask

    task automatic run_job(input int n, input bit s, input bit bubbles, input int hold);
        int t0, tv;
        send_cfg(n, s, 1'b1, t0);
        feed(n, bubbles);
        get_result(hold, s, tv);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, tv, l0;
        bus.cfg_valid_i  = 1'b0;
        bus.cfg_beats_i  = '0;
        bus.cfg_signed_i = 1'b0;
        bus.in_valid_i   = 1'b0;
        bus.out_ready_i  = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Unsigned back-to-back job and its end-to-end latency.
        sums[0] = 16'd10; sums[1] = 16'd20; sums[2] = 16'd30; sums[3] = 16'd40;
        send_cfg(4, 1'b0, 1'b1, t0);
        feed(4, 1'b0);
        get_result(0, 1'b0, tv);
        chk("latency", 64'(tv - t0), 64'(4 + TREE_LAT));

        // Same sums reduced signed and unsigned.
        sums[0] = 16'hFFFF; sums[1] = 16'hFFFE; sums[2] = 16'h0005;
        run_job(3, 1'b1, 1'b0, 1);
        run_job(3, 1'b0, 1'b0, 0);

        // Empty job goes straight to DONE and ignores offered beats.
        l0 = launches;
        send_cfg(0, 1'b0, 1'b1, t0);
        bus.in_valid_i = 1'b1;
        chk("zero_done_next", 64'(bus.out_valid_o), 64'(1));
        get_result(5, 1'b0, tv);
        bus.in_valid_i = 1'b0;
        chk("zero_launches", 64'(launches - l0), 64'(0));

        // Bubbled input stream.
        for (int i = 0; i < 5; i++) sums[i] = SUM_W'($urandom);
        l0 = launches;
        send_cfg(5, 1'b0, 1'b1, t0);
        feed(5, 1'b1);
        chk("in_ready_drop", 64'(bus.in_ready_o), 64'(0));
        chk("launch_count", 64'(launches - l0), 64'(5));
        get_result(2, 1'b0, tv);

        // Reset while beats are still in flight; the following job must not see them.
        for (int i = 0; i < 4; i++) sums[i] = SUM_W'($urandom);
        send_cfg(4, 1'b1, 1'b0, t0);
        feed(4, 1'b0);
        chk("drain_busy", 64'(bus.busy_o), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midjob_reset");
        sums[0] = 16'd7;
        run_job(1, 1'b0, 1'b0, 0);

        // Full-length signed job of most-negative sums.
        for (int i = 0; i < MAX_BEATS; i++) sums[i] = 16'h8000;
        run_job(MAX_BEATS, 1'b1, 1'b1, 1);

        // Randomised jobs.
        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(0, 24);
            for (int i = 0; i < n; i++) sums[i] = SUM_W'($urandom);
            run_job(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        repeat (4) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adder_tree_acc_ctrl.md
Name: adder_tree_acc_ctrl

Overview:
- Sequences multi-beat reductions through an external pipelined adder tree that is built from adder tree layers plus optional pipeline registers.
- Accepts a job configuration (beat count, signed/unsigned mode), then streams input beats to the tree under valid/ready.
- Tracks in-flight beats across the tree latency and accumulates per-beat tree sums into a wide accumulator.
- Returns one scalar result per job on a valid/ready output. Sits between the stream front-end and the tree in the compute datapath.

Parameters:
- SUM_W, 16, width of the tree's final sum (tree output width).
- TREE_LAT, 2, fixed tree latency in cycles from beat launch to sum valid; 0 means combinational.
- MAX_BEATS, 256, maximum beats per job.
- BEAT_CNT_W, $clog2(MAX_BEATS+1), derived; beat-count width.
- ACC_W, SUM_W+$clog2(MAX_BEATS), derived; accumulator and result width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_valid_i  in  1  job config valid.
- cfg_ready_o  out  1  controller idle; accepts config.
- cfg_beats_i  in  BEAT_CNT_W  beats in job (0..MAX_BEATS).
- cfg_signed_i  in  1  1 = signed, 0 = unsigned reduction.
- in_valid_i  in  1  input beat valid (data routed directly to tree).
- in_ready_o  out  1  controller accepts beat.
- tree_launch_o  out  1  beat launched into tree this cycle (= in_valid_i & in_ready_o).
- tree_sign_unsign_no  out  1  drives tree sign_unsign_ni; latched cfg_signed_i, held for the whole job.
- tree_sum_i  in  SUM_W  tree result, valid TREE_LAT cycles after the matching launch.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts result.
- out_result_o  out  ACC_W  accumulated sum.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset values: all outputs 0, except cfg_ready_o = 1 (IDLE). Reset also clears the accumulator, beat counters, valid shift register and mode latch. Reset mid-job abandons the job; in-flight tree sums are ignored.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - cfg_ready_o = 1.
  - On cfg_valid_i: latch beats and signed, clear acc and counters.
  - beats == 0 -> DONE (result 0), else -> RUN.
- RUN:
  - in_ready_o = 1 while launched < beats.
  - Each launch increments the launched counter and pushes 1 into a TREE_LAT-deep valid shift register; cycles without a launch push 0.
  - When the last beat launches -> DRAIN the next cycle. If TREE_LAT == 0, go to DONE once its sum has accumulated.
- Accumulation:
  - When the shift-register output is 1, acc <= acc + ext(tree_sum_i).
  - ext = sign-extend to ACC_W if signed, else zero-extend.
  - Modulo 2^ACC_W; no overflow is possible within MAX_BEATS.
  - Increment the retired counter.
  - Active in both RUN and DRAIN.
- DRAIN: in_ready_o = 0. When retired == beats (after the final accumulate) -> DONE.
- DONE:
  - out_valid_o = 1; out_result_o = acc, held stable until out_ready_i.
  - On handshake -> IDLE, with cfg_ready_o = 1 the next cycle.
  - A new config is never accepted in the same cycle as the output handshake.
- Latency, beats N with no input bubbles: last launch at cycle N-1 after config; out_valid_o at cycle N+TREE_LAT.
- Input bubbles (in_valid_i = 0) insert 0s into the valid shift register; the count is unaffected.
- tree_sign_unsign_no is constant from the config latch until IDLE. The tree is non-stallable, so in-flight beats always retire.
- in_ready_o is 0 outside RUN. Beats presented in IDLE/DRAIN/DONE are not consumed.
- Assertions (sim only):
  - cfg_beats_i <= MAX_BEATS on config.
  - out_result_o stable while out_valid_o & !out_ready_i.

Optional Feature:
- Macro: ADDER_TREE_ACC_CTRL_PERF_EN.
- When defined, adds:
  - a 32-bit output perf_busy_cycles_o, counting cycles with busy_o = 1;
  - a 32-bit output perf_stall_cycles_o, counting RUN cycles with in_ready_o & !in_valid_i, plus DONE cycles with !out_ready_i.
- Both counters saturate at 2^32-1 and reset to 0 on rst_i.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Unsigned, TREE_LAT=2, beats=4, tree sums 10, 20, 30, 40 back-to-back -> out_result_o = 100, out_valid_o at cycle 6 after config; tree_sign_unsign_no = 0.
- Signed, beats=3, sums 0xFFFF, 0xFFFE, 0x0005 (SUM_W=16) -> result 2; the same sums in unsigned mode -> result 0x20002.
- beats=0 -> DONE the next cycle, result 0, no tree_launch_o pulses; hold out_ready_i low 5 cycles -> result stable, cfg_ready_o = 0.
- beats=5 with bubbles (in_valid_i toggling) -> exactly 5 launches, in_ready_o drops after the 5th, result equals the sum of the 5 sums.
- Assert rst_i in DRAIN with 2 beats in flight -> cycle after reset: IDLE, outputs at reset values; the next job (beats=1, sum 7) -> result 7, unaffected by stale sums.
- MAX_BEATS=256 signed, all sums 0x8000 -> result -8388608 in ACC_W=24 (0x800000), no wrap.
